// File: rtl/cache_req_issuer_if.sv
`default_nettype none
//============================================================================
// Module      : cache_req_issuer_if
// Description : Request-in / operation-out bundle for cache_req_issuer.
//               The slave modport is the issuer itself; the master modport
//               is whatever feeds requests and observes issued operations.
// Revision    : 1.0 - initial release
//============================================================================
interface cache_req_issuer_if #(
  parameter int ADDR_W = 32,
  parameter int CMD_W  = 4,
  parameter int DEPTH  = 8
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Upstream request channel
  logic              in_valid;
  logic              in_ready;
  logic [CMD_W-1:0]  in_cmd;
  logic [ADDR_W-1:0] in_addr;

  // Downstream operation channel
  logic              valid;
  logic [CMD_W-1:0]  cmd_out;
  logic [ADDR_W-1:0] addr_out;
  logic              opr_finished;

  // Status
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;
  logic              drop_err;
  logic              timeout;

  modport slave (
    input  in_valid, in_cmd, in_addr, opr_finished,
    output in_ready, valid, cmd_out, addr_out, busy, fifo_count,
           drop_err, timeout
  );

  modport master (
    output in_valid, in_cmd, in_addr, opr_finished,
    input  in_ready, valid, cmd_out, addr_out, busy, fifo_count,
           drop_err, timeout
  );

endinterface
`default_nettype wire

// File: rtl/cache_req_issuer.sv
`default_nettype none
//============================================================================
// Module      : cache_req_issuer
// Description : Request queue in front of the cache operation controller.
//               Accepts (cmd, addr) requests into a DEPTH-entry FIFO, drops
//               illegal commands with a drop_err pulse, and issues one
//               operation at a time: single-cycle valid, then wait for
//               opr_finished, then one GAP cycle before the next issue.
//               Optional watchdog: define CACHE_REQ_TIMEOUT_EN to abandon an
//               operation after TIMEOUT cycles in WAIT (timeout pulse).
// Revision    : 1.0 - initial release
//============================================================================
module cache_req_issuer #(
  parameter int ADDR_W  = 32,
  parameter int CMD_W   = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  cache_req_issuer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [CMD_W-1:0]  r_mem_cmd  [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_drop_err;

  state_t            r_state;
  logic              r_valid;
  logic              r_busy;
  logic [CMD_W-1:0]  r_cmd;
  logic [ADDR_W-1:0] r_addr;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_cmd_legal;
  logic              w_push;
  logic              w_pop;
  logic [CMD_W-1:0]  w_head_cmd;
  logic [ADDR_W-1:0] w_head_addr;

  // Only the command codes the operation controller understands are queued.
  function automatic logic f_cmd_legal(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_W'(0)) || (cmd == CMD_W'(1)) || (cmd == CMD_W'(2)) ||
           (cmd == CMD_W'(3)) || (cmd == CMD_W'(4)) || (cmd == CMD_W'(8)) ||
           (cmd == CMD_W'(9));
  endfunction

  // --------------------------------------------------------------------------
  // Handshake and FIFO control
  // --------------------------------------------------------------------------
  // Space is judged on the registered count only, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign w_in_ready  = (r_count != c_full_count);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_cmd_legal = f_cmd_legal(bus.in_cmd);
  assign w_push      = w_accept && w_cmd_legal;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_cmd  = r_mem_cmd[r_rd_ptr];
  assign w_head_addr = r_mem_addr[r_rd_ptr];

  // Entry storage: plain RAM, contents are qualified by the count so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cmd[r_wr_ptr]  <= bus.in_cmd;
      r_mem_addr[r_wr_ptr] <= bus.in_addr;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Illegal commands complete the handshake but only raise a one-cycle flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_err <= 1'b0;
    end else begin
      r_drop_err <= w_accept && !w_cmd_legal;
    end
  end

  // --------------------------------------------------------------------------
  // Issue FSM
  // --------------------------------------------------------------------------
`ifdef CACHE_REQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] c_wdog_last = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] r_wdog;
  logic            r_timeout;
`endif

  // Sequences one operation at a time; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_cmd     <= '0;
      r_addr    <= '0;
`ifdef CACHE_REQ_TIMEOUT_EN
      r_wdog    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_valid   <= 1'b0;
`ifdef CACHE_REQ_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          // The head is latched here and held until the next issue.
          if (w_pop) begin
            r_cmd   <= w_head_cmd;
            r_addr  <= w_head_addr;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // opr_finished here belongs to a previous operation; ignore it.
`ifdef CACHE_REQ_TIMEOUT_EN
          r_wdog  <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.opr_finished) begin
            r_state <= S_GAP;
`ifdef CACHE_REQ_TIMEOUT_EN
          end else if (r_wdog == c_wdog_last) begin
            r_timeout <= 1'b1;
            r_state   <= S_GAP;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
`endif
          end
        end
        S_GAP: begin
          // One idle cycle so the controller's own counter can clear.
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.valid      = r_valid;
  assign bus.cmd_out    = r_cmd;
  assign bus.addr_out   = r_addr;
  assign bus.busy       = r_busy;
  assign bus.fifo_count = r_count;
  assign bus.drop_err   = r_drop_err;

`ifdef CACHE_REQ_TIMEOUT_EN
  assign bus.timeout    = r_timeout;
`else
  // Watchdog compiled out: an operation may wait indefinitely.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign bus.timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_req_issuer.sv
`default_nettype none
//============================================================================
// Module      : tb_cache_req_issuer
// Description : Directed self-checking bench for cache_req_issuer.
// Revision    : 1.0 - initial release
//============================================================================
module tb_cache_req_issuer;

  localparam int ADDR_W  = 32;
  localparam int CMD_W   = 4;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  // Monitor records of every valid pulse, drop and timeout pulse.
  int                v_cyc  [$];
  logic [CMD_W-1:0]  v_cmd  [$];
  logic [ADDR_W-1:0] v_addr [$];
  int                drop_n = 0;
  int                to_n   = 0;

  cache_req_issuer_if #(.ADDR_W(ADDR_W), .CMD_W(CMD_W), .DEPTH(DEPTH)) bus ();

  cache_req_issuer #(
    .ADDR_W (ADDR_W),
    .CMD_W  (CMD_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid) begin
      v_cyc.push_back(cyc);
      v_cmd.push_back(bus.cmd_out);
      v_addr.push_back(bus.addr_out);
    end
    if (bus.drop_err) drop_n++;
    if (bus.timeout)  to_n++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_cmd       = '0;
    bus.in_addr      = '0;
    bus.opr_finished = 1'b0;
  endtask

  task automatic push(input logic [CMD_W-1:0] c, input logic [ADDR_W-1:0] a);
    bus.in_valid = 1'b1;
    bus.in_cmd   = c;
    bus.in_addr  = a;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [CMD_W-1:0] legal [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};

  initial begin
    int base;
    int dbase;
    int tbase;
    int maxf;
    int fin_at;
    int c;
    int to_cyc;
    int v1;
    int v2;

    idle_inputs();

    // ---------------- Reset state ----------------
    tick();
    check("rst_valid",    bus.valid,      0);
    check("rst_busy",     bus.busy,       0);
    check("rst_fifo",     bus.fifo_count, 0);
    check("rst_cmd",      bus.cmd_out,    0);
    check("rst_addr",     bus.addr_out,   0);
    check("rst_drop",     bus.drop_err,   0);
    check("rst_timeout",  bus.timeout,    0);
    tick();
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready,   1);

    // ---------------- Single request, latency ----------------
    push(4'd1, 32'h0000_1234);                 // cycle 0
    tick();                                    // cycle 1
    idle_inputs();
    check("t1_c1_valid", bus.valid, 0);
    check("t1_c1_fifo",  bus.fifo_count, 1);
    tick();                                    // cycle 2: ISSUE
    check("t1_valid",    bus.valid, 1);
    check("t1_cmd",      bus.cmd_out, 1);
    check("t1_addr",     bus.addr_out, 32'h0000_1234);
    check("t1_busy",     bus.busy, 1);
    check("t1_c2_fifo",  bus.fifo_count, 0);
    bus.opr_finished = 1'b1;                   // coincides with ISSUE: ignored
    tick();                                    // cycle 3
    bus.opr_finished = 1'b0;
    check("t1_c3_valid", bus.valid, 0);
    check("t1_c3_addr",  bus.addr_out, 32'h0000_1234);
    tick();                                    // cycle 4
    tick();                                    // cycle 5
    check("t1_c5_busy",  bus.busy, 1);
    tick();                                    // cycle 6
    bus.opr_finished = 1'b1;
    tick();                                    // cycle 7: GAP
    bus.opr_finished = 1'b0;
    check("t1_c7_busy",  bus.busy, 1);
    tick();                                    // cycle 8: IDLE
    check("t1_c8_busy",  bus.busy, 0);

    // ---------------- Fill: 9 accepts, 8 queued + 1 in flight ----------------
    reset_dut();
    base = v_cyc.size();
    for (int i = 0; i < 9; i++) begin
      check("t2_in_ready", bus.in_ready, 1);
      push(legal[i % 7], 32'h100 + 32'(i));
      tick();
    end
    check("t2_full_ready", bus.in_ready, 0);
    check("t2_full_count", bus.fifo_count, 8);
    push(4'd4, 32'hDEAD);                       // refused while full
    tick();
    tick();
    idle_inputs();
    check("t2_still_8",    bus.fifo_count, 8);
    check("t2_n_valid",    v_cyc.size() - base, 1);
    if (v_cyc.size() > base) begin
      check("t2_first_cmd",  v_cmd[base],  0);
      check("t2_first_addr", v_addr[base], 32'h100);
    end

    // ---------------- Illegal command dropped ----------------
    reset_dut();
    base  = v_cyc.size();
    dbase = drop_n;
    maxf  = 0;
    push(4'd5, 32'h55);                         // cycle 0
    tick();                                     // cycle 1
    check("t3_drop_c1", bus.drop_err, 1);
    check("t3_fifo_c1", bus.fifo_count, 0);
    push(4'd0, 32'h66);
    tick();                                     // cycle 2
    idle_inputs();
    check("t3_drop_c2", bus.drop_err, 0);
    check("t3_fifo_c2", bus.fifo_count, 1);
    tick();                                     // cycle 3
    check("t3_valid",   bus.valid, 1);
    check("t3_cmd",     bus.cmd_out, 0);
    check("t3_addr",    bus.addr_out, 32'h66);
    bus.opr_finished = 1'b1;                    // ignored in ISSUE
    tick();                                     // cycle 4
    for (int i = 0; i < 4; i++) begin
      if (int'(bus.fifo_count) > maxf) maxf = int'(bus.fifo_count);
      bus.opr_finished = (i == 0);
      tick();
    end
    bus.opr_finished = 1'b0;
    check("t3_max_fifo",  maxf, 0);
    check("t3_n_drop",    drop_n - dbase, 1);
    check("t3_n_valid",   v_cyc.size() - base, 1);
    check("t3_idle_busy", bus.busy, 0);

    // ---------------- Three requests, spacing and order ----------------
    reset_dut();
    base = v_cyc.size();
    push(4'd2, 32'hA0); tick();
    push(4'd3, 32'hB0); tick();
    push(4'd4, 32'hC0);
    c      = 2;
    fin_at = -1;
    for (int i = 0; i < 40; i++) begin
      bus.opr_finished = (c == fin_at);
      if (bus.valid) fin_at = c + 2;
      tick();
      c++;
      if (c == 3) bus.in_valid = 1'b0;
    end
    idle_inputs();
    check("t4_n_valid", v_cyc.size() - base, 3);
    if (v_cyc.size() >= base + 3) begin
      check("t4_space1", v_cyc[base+1] - v_cyc[base],   5);
      check("t4_space2", v_cyc[base+2] - v_cyc[base+1], 5);
      check("t4_cmd0",   v_cmd[base],    2);
      check("t4_cmd1",   v_cmd[base+1],  3);
      check("t4_cmd2",   v_cmd[base+2],  4);
      check("t4_addr2",  v_addr[base+2], 32'hC0);
    end

    // ---------------- Reset during WAIT with 4 queued ----------------
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      push(legal[i+1], 32'h200 + 32'(i));
      tick();
    end
    idle_inputs();
    check("t5_pre_fifo", bus.fifo_count, 4);
    check("t5_pre_busy", bus.busy, 1);
    #3;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", bus.valid, 0);
    check("t5_rst_busy",  bus.busy, 0);
    check("t5_rst_fifo",  bus.fifo_count, 0);
    tick();
    rst  = 1'b0;
    base = v_cyc.size();
    for (int i = 0; i < 10; i++) tick();
    check("t5_no_valid",  v_cyc.size() - base, 0);
    check("t5_post_busy", bus.busy, 0);
    check("t5_post_rdy",  bus.in_ready, 1);

    // ---------------- Watchdog ----------------
    reset_dut();
    tbase  = to_n;
    to_cyc = -1;
    v1     = -1;
    v2     = -1;
    push(4'd8, 32'hA000); tick();
    push(4'd9, 32'hB000); tick();
    idle_inputs();
    c = 2;
    for (int i = 0; i < 100; i++) begin
      if (bus.timeout && to_cyc < 0) to_cyc = c;
      if (bus.valid) begin
        if (v1 < 0) v1 = c;
        else if (v2 < 0) begin
          v2 = c;
          check("t6_second_cmd", bus.cmd_out, 9);
        end
      end
      tick();
      c++;
    end
    check("t6_first_valid", v1, 2);
`ifdef CACHE_REQ_TIMEOUT_EN
    check("t6_timeout_cyc", to_cyc, 67);
    check("t6_second_at",   v2, 69);
    check("t6_n_timeout",   to_n - tbase, 1);
`else
    check("t6_no_timeout",  to_n - tbase, 0);
    check("t6_no_second",   v2 < 0, 1);
    check("t6_still_busy",  bus.busy, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
